snn_banked_mem_ctrl: RTL

SNN_BANKED_MEM_CTRL -- requirements
Module: snn_banked_mem_ctrl

---
 rtl/snn_mem_pkg.sv | 22 ++
 rtl/snn_mem_bank.sv | 46 ++++
 rtl/snn_banked_mem_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/snn_mem_pkg.sv
// snn_mem_pkg
//   Shared address-map constants for the banked SNN memory controller.
//   The 16-bit byte address is split into a bank select and a word offset
//   within the bank; the two lowest bits (byte lane) are not decoded.
package snn_mem_pkg;

  localparam int ADDR_W    = 16;

  // Bank select field
  localparam int BANK_HI   = 15;
  localparam int BANK_LO   = 13;
  localparam int BANK_W    = BANK_HI - BANK_LO + 1;

  // Word offset field inside a bank
  localparam int OFF_HI    = 12;
  localparam int OFF_LO    = 2;
  localparam int OFF_W     = OFF_HI - OFF_LO + 1;

  // Largest number of banks the bank field can address
  localparam int MAX_BANKS = 1 << BANK_W;

endpackage

// File: rtl/snn_mem_bank.sv
// snn_mem_bank
//   Single-port RAM with per-byte write enables and a registered read,
//   written so synthesis maps it onto block RAM.
//   Ports:
//     clk    rising-edge clock
//     en     access enable (one access per cycle)
//     we     1 = write enabled bytes, 0 = read
//     addr   word address
//     wdata  write data
//     be     byte enables for writes
//     rdata  read data, valid the cycle after a read access
module snn_mem_bank #(
  parameter int DEPTH = 1024,
  parameter int DW    = 32,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     wdata,
  input  logic [DW/8-1:0]   be,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_reg;

  // No reset: contents and the read register survive reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < DW/8; b++) begin
          if (be[b]) begin
            mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end else begin
        rdata_reg <= mem[addr];
      end
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/snn_banked_mem_ctrl.sv
// snn_banked_mem_ctrl
//   Multi-port front end to NUM_BANKS independent RAM banks. Each bank runs
//   its own round-robin arbiter, so ports hitting different banks are served
//   in the same cycle. Unmapped addresses are accepted at once and answered
//   with an error response without touching memory.
//   Ports:
//     clk, rst                clock, asynchronous active-high reset
//     req_valid/req_ready     per-port request handshake (ready is combinational)
//     req_we                  per-port write (1) / read (0)
//     req_addr                16-bit byte address per port, port 0 in LSBs
//     req_wdata, req_be       write data and byte enables per port
//     rsp_valid               response strobe, one cycle after acceptance
//     rsp_rdata               read data (0 for writes and errors)
//     rsp_err                 unmapped-address flag, qualified by rsp_valid
module snn_banked_mem_ctrl
  import snn_mem_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int NUM_BANKS = 8,
  parameter int DEPTH     = 1024,
  parameter int DW        = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [16*NUM_PORTS-1:0]     req_addr,
  input  logic [DW*NUM_PORTS-1:0]     req_wdata,
  input  logic [(DW/8)*NUM_PORTS-1:0] req_be,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic [DW*NUM_PORTS-1:0]     rsp_rdata,
  output logic [NUM_PORTS-1:0]        rsp_err
);

  localparam int NB  = (NUM_BANKS < MAX_BANKS) ? NUM_BANKS : MAX_BANKS;
  localparam int BEW = DW / 8;
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [BANK_W-1:0]      p_bank [NUM_PORTS];
  logic [OFF_W-1:0]       p_off  [NUM_PORTS];
  logic [NUM_PORTS-1:0]   p_mapped;
  logic [2*NUM_PORTS-1:0] unused_addr_lo;
  logic [NUM_PORTS-1:0]   gnt [NB];
  logic [NUM_PORTS-1:0]   gnt_any;
  logic [DW-1:0]          bank_rdata [NB];

  genvar gi;

  // Address decode per port
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_dec
      assign p_bank[gi]   = req_addr[gi*ADDR_W + BANK_LO +: BANK_W];
      assign p_off[gi]    = req_addr[gi*ADDR_W + OFF_LO +: OFF_W];
      // Full offset is compared so an out-of-range offset never aliases.
      assign p_mapped[gi] = (32'(p_bank[gi]) < NB) && (32'(p_off[gi]) < DEPTH);
      assign unused_addr_lo[gi*2 +: 2] = req_addr[gi*ADDR_W +: 2];
    end
  endgenerate

  // Per-bank arbiter, port mux and RAM
  generate
    for (gi = 0; gi < NB; gi++) begin : g_bank
      logic [PW-1:0]        rr_reg;
      logic [PW-1:0]        win;
      logic [NUM_PORTS-1:0] gnt_v;
      logic                 b_we;
      logic [AW-1:0]        b_addr;
      logic [DW-1:0]        b_wdata;
      logic [BEW-1:0]       b_be;
      int                   best;
      int                   rank;

      // Winner is the requesting port closest at or after the pointer.
      always_comb begin
        gnt_v = '0;
        win   = '0;
        best  = NUM_PORTS;
        rank  = 0;
        for (int p = 0; p < NUM_PORTS; p++) begin
          rank = (p >= int'(rr_reg)) ? p - int'(rr_reg) : p + NUM_PORTS - int'(rr_reg);
          if (req_valid[p] && p_mapped[p] && (32'(p_bank[p]) == 32'(gi)) && rank < best) begin
            best     = rank;
            win      = PW'(p);
            gnt_v    = '0;
            gnt_v[p] = 1'b1;
          end
        end
      end

      always_comb begin
        b_we    = 1'b0;
        b_addr  = '0;
        b_wdata = '0;
        b_be    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (gnt_v[p]) begin
            b_we    = req_we[p];
            b_addr  = p_off[p][AW-1:0];
            b_wdata = req_wdata[p*DW +: DW];
            b_be    = req_be[p*BEW +: BEW];
          end
        end
      end

      // Pointer moves past the winner only when the bank grants.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rr_reg <= '0;
        end else if (|gnt_v) begin
          rr_reg <= (int'(win) == NUM_PORTS - 1) ? '0 : win + 1'b1;
        end
      end

      assign gnt[gi] = gnt_v;

      snn_mem_bank #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_bank (
        .clk   (clk),
        .en    (|gnt_v),
        .we    (b_we),
        .addr  (b_addr),
        .wdata (b_wdata),
        .be    (b_be),
        .rdata (bank_rdata[gi])
      );
    end
  endgenerate

  always_comb begin
    gnt_any = '0;
    for (int b = 0; b < NB; b++) begin
      gnt_any = gnt_any | gnt[b];
    end
  end

  // Unmapped requests bypass arbitration and are always taken.
  assign req_ready = req_valid & (~p_mapped | gnt_any);

  // Response pipeline per port
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rsp
      logic              valid_reg;
      logic              err_reg;
      logic              rd_reg;
      logic [BANK_W-1:0] bank_reg;
      logic [DW-1:0]     rd_mux;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
          err_reg   <= 1'b0;
          rd_reg    <= 1'b0;
          bank_reg  <= '0;
        end else begin
          valid_reg <= req_ready[gi];
          err_reg   <= req_ready[gi] && !p_mapped[gi];
          rd_reg    <= req_ready[gi] && p_mapped[gi] && !req_we[gi];
          bank_reg  <= p_bank[gi];
        end
      end

      // The bank's read register holds this port's data for exactly this cycle.
      always_comb begin
        rd_mux = '0;
        for (int b = 0; b < NB; b++) begin
          if (32'(bank_reg) == 32'(b)) begin
            rd_mux = bank_rdata[b];
          end
        end
      end

      assign rsp_valid[gi]           = valid_reg;
      assign rsp_err[gi]             = err_reg;
      assign rsp_rdata[gi*DW +: DW]  = rd_reg ? rd_mux : '0;
    end
  endgenerate

endmodule
